// File: rtl/core_pkg.sv
// Shared widths, micro-op control encodings and the write-back entry layout.
// Pure declarations, no logic and no latency.
// Nothing here stalls; flow control lives in the modules that import it.
package core_pkg;

    // Datapath width of the core (32 or 64)
    localparam int DATA_WIDTH        = 32;
    // Byte-offset bits within one data word
    localparam int ADDR_OFFSET_WIDTH = $clog2(DATA_WIDTH / 8);
    localparam int MEM_CTRL_WIDTH    = 4;
    localparam int GPR_CTRL_WIDTH    = 2;
    localparam int RF_ADDR_WIDTH     = 5;

    // Memory operation codes: bit 3 clear marks a read, set marks a write.
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RB   = 4'b0000;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RBU  = 4'b0001;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RH   = 4'b0010;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RHU  = 4'b0011;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RW   = 4'b0100;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RWU  = 4'b0101;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RD   = 4'b0110;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WB   = 4'b1000;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WH   = 4'b1001;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WW   = 4'b1010;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WD   = 4'b1011;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_IDLE = 4'b1111;

    // Source of the GPR write data
    localparam logic [GPR_CTRL_WIDTH-1:0] GPR_IDLE = 2'b00;
    localparam logic [GPR_CTRL_WIDTH-1:0] GPR_EXE  = 2'b01;
    localparam logic [GPR_CTRL_WIDTH-1:0] GPR_MEM  = 2'b10;

    // One buffered write-back result
    typedef struct packed {
        logic [GPR_CTRL_WIDTH-1:0] src;
        logic [RF_ADDR_WIDTH-1:0]  rd;
        logic [DATA_WIDTH-1:0]     dat;
    } wb_entry_t;

endpackage

// File: rtl/load_aligner.sv
// Extracts and sign/zero-extends load data from a raw data-memory word.
// Purely combinational, zero cycles.
// No flow control; output follows inputs every cycle.
module load_aligner
    import core_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic [ADDR_OFFSET_WIDTH-1:0] offset,
    input  logic [MEM_CTRL_WIDTH-1:0]    mem_ctrl,
    output logic [DATA_WIDTH-1:0]        data
);

    logic [ADDR_OFFSET_WIDTH+2:0] shamt;
    logic [DATA_WIDTH-1:0]        shifted;

    // Byte offset to bit shift; bytes pulled in past the word top read as zero,
    // so misaligned accesses simply see zeros in the missing bytes.
    assign shamt   = {offset, 3'b000};
    assign shifted = rdata >> shamt;

    // Pick the access size and extend it to the full register width
    always_comb begin
        data = shifted;
        case (mem_ctrl)
            MEM_RB:  data = DATA_WIDTH'($signed(shifted[7:0]));
            MEM_RBU: data = DATA_WIDTH'(shifted[7:0]);
            MEM_RH:  data = DATA_WIDTH'($signed(shifted[15:0]));
            MEM_RHU: data = DATA_WIDTH'(shifted[15:0]);
            // On a 32-bit core both word loads reduce to the word itself
            MEM_RW:  data = DATA_WIDTH'($signed(shifted[31:0]));
            MEM_RWU: data = DATA_WIDTH'(shifted[31:0]);
            MEM_RD:  data = shifted;
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: buffers MEM results in order and drives the GPR write port.
// Latency: a result accepted at an edge retires in the following cycle when empty.
// Backpressure: two-entry buffer; ready_o drops only when both entries are held.
module wb_unit
    import core_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      mem_valid_i,
    output logic                      ready_o,
    input  logic [DATA_WIDTH-1:0]     exe_out_i,
    input  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_i,
    input  logic [DATA_WIDTH-1:0]     d_m_rdata_i,
    input  logic [GPR_CTRL_WIDTH-1:0] gpr_ctrl_i,
    input  logic [RF_ADDR_WIDTH-1:0]  rd_i,
    input  logic                      halt_i,
    output logic                      rf_wren_o,
    output logic [RF_ADDR_WIDTH-1:0]  rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      commit_o,
    output logic [63:0]               instret_o
);

    // Buffer occupancy states
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    wb_entry_t             head;
    wb_entry_t             skid;
    wb_entry_t             incoming;
    logic [1:0]            count;
    logic [63:0]           instret;
    logic [DATA_WIDTH-1:0] load_dat;
    logic                  in_rdy;
    logic                  accept;
    logic                  retire;

    load_aligner u_load_aligner (
        .rdata    (d_m_rdata_i),
        .offset   (exe_out_i[ADDR_OFFSET_WIDTH-1:0]),
        .mem_ctrl (mem_ctrl_i),
        .data     (load_dat)
    );

    // Build the entry at capture time so the buffer never holds raw memory words
    always_comb begin
        incoming     = '0;
        incoming.src = gpr_ctrl_i;
        incoming.rd  = rd_i;
        incoming.dat = (gpr_ctrl_i == GPR_MEM) ? load_dat : exe_out_i;
    end

    assign in_rdy  = (count != CNT_FULL);
    assign accept  = mem_valid_i && in_rdy;
    assign retire  = (count != CNT_EMPTY) && !halt_i;

    // Reset forces ready low immediately, independent of the clock
    assign ready_o = rstn_i && in_rdy;

    // Head/skid buffer: the skid entry only fills while the head is stalled
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count <= CNT_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            case (count)
                CNT_EMPTY: begin
                    if (accept) begin
                        head  <= incoming;
                        count <= CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (retire && accept) begin
                        head <= incoming;
                    end else if (retire) begin
                        count <= CNT_EMPTY;
                    end else if (accept) begin
                        skid  <= incoming;
                        count <= CNT_FULL;
                    end
                end
                default: begin
                    // Full: no accept possible, retiring promotes the skid entry
                    if (retire) begin
                        head  <= skid;
                        count <= CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Retired-uop counter, wraps naturally at 2^64
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end

    assign commit_o   = retire;
    assign rf_wren_o  = retire && (head.src != GPR_IDLE) && (head.rd != '0);
    assign rf_waddr_o = (count != CNT_EMPTY) ? head.rd  : '0;
    assign rf_wdata_o = (count != CNT_EMPTY) ? head.dat : '0;
    assign instret_o  = instret;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: vector table, halt, throughput and reset sequences.
// Inputs change 1 time unit after a rising edge; outputs are sampled on falling edges.
// Expected retirements are queued at acceptance and compared when commit_o pulses.
module tb_wb_unit;
    import core_pkg::*;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      mem_valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     exe_out;
    logic [MEM_CTRL_WIDTH-1:0] mem_ctrl;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [GPR_CTRL_WIDTH-1:0] gpr_ctrl;
    logic [RF_ADDR_WIDTH-1:0]  rd;
    logic                      halt;
    logic                      rf_wren;
    logic [RF_ADDR_WIDTH-1:0]  rf_waddr;
    logic [DATA_WIDTH-1:0]     rf_wdata;
    logic                      commit;
    logic [63:0]               instret;

    int total = 0;
    int bad = 0;
    int commit_cnt = 0;
    int cc0;

    always #5 clk = ~clk;

    wb_unit dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .mem_valid_i (mem_valid),
        .ready_o     (ready),
        .exe_out_i   (exe_out),
        .mem_ctrl_i  (mem_ctrl),
        .d_m_rdata_i (rdata),
        .gpr_ctrl_i  (gpr_ctrl),
        .rd_i        (rd),
        .halt_i      (halt),
        .rf_wren_o   (rf_wren),
        .rf_waddr_o  (rf_waddr),
        .rf_wdata_o  (rf_wdata),
        .commit_o    (commit),
        .instret_o   (instret)
    );

    typedef struct {
        logic                     wren;
        logic [RF_ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0]    wdata;
        logic                     chk_dat;
    } exp_t;

    typedef struct {
        logic [MEM_CTRL_WIDTH-1:0] mc;
        logic [GPR_CTRL_WIDTH-1:0] gc;
        logic [DATA_WIDTH-1:0]     eo;
        logic [DATA_WIDTH-1:0]     rdat;
        logic [RF_ADDR_WIDTH-1:0]  r;
        logic                      ew;
        logic [DATA_WIDTH-1:0]     ed;
        logic                      cd;
    } vec_t;

    exp_t sb[$];
    exp_t cur_exp;
    exp_t mon_e;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        mem_ctrl  = MEM_IDLE;
        gpr_ctrl  = GPR_IDLE;
        exe_out   = '0;
        rdata     = '0;
        rd        = '0;
    endtask

    task automatic drive(input vec_t v);
        mem_valid = 1'b1;
        mem_ctrl  = v.mc;
        gpr_ctrl  = v.gc;
        exe_out   = v.eo;
        rdata     = v.rdat;
        rd        = v.r;
        cur_exp   = '{wren: v.ew, waddr: v.r, wdata: v.ed, chk_dat: v.cd};
    endtask

    task automatic exe_uop(input logic [RF_ADDR_WIDTH-1:0] r, input logic [DATA_WIDTH-1:0] val);
        vec_t v;
        v = '{MEM_IDLE, GPR_EXE, val, '0, r, (r != '0), val, 1'b1};
        drive(v);
    endtask

    // Scoreboard: pop and compare on each commit, then record this cycle's acceptance
    always @(negedge clk) begin
        if (commit) begin
            commit_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_commit actual=commit required=no_commit");
            end else begin
                mon_e = sb.pop_front();
                check("sb_wren", 64'(rf_wren), 64'(mon_e.wren));
                check("sb_waddr", 64'(rf_waddr), 64'(mon_e.waddr));
                if (mon_e.chk_dat) check("sb_wdata", 64'(rf_wdata), 64'(mon_e.wdata));
            end
        end
        if (mem_valid && ready) sb.push_back(cur_exp);
    end

    initial begin
        vecs[0] = '{MEM_RB,  GPR_MEM, 32'h0000_0103, 32'h8011_2233, 5'd5,  1'b1, 32'hFFFF_FF80, 1'b1};
        vecs[1] = '{MEM_RHU, GPR_MEM, 32'h0000_0202, 32'hBEEF_1234, 5'd6,  1'b1, 32'h0000_BEEF, 1'b1};
        vecs[2] = '{MEM_IDLE, GPR_EXE, 32'h0000_0055, 32'h0000_0000, 5'd0, 1'b0, 32'h0000_0055, 1'b1};
        vecs[3] = '{MEM_RBU, GPR_MEM, 32'h0000_0101, 32'h8011_2233, 5'd7,  1'b1, 32'h0000_0022, 1'b1};
        vecs[4] = '{MEM_RH,  GPR_MEM, 32'h0000_0000, 32'h1234_F00D, 5'd8,  1'b1, 32'hFFFF_F00D, 1'b1};
        vecs[5] = '{MEM_RW,  GPR_MEM, 32'h0000_0000, 32'hDEAD_BEEF, 5'd31, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vecs[6] = '{MEM_RW,  GPR_MEM, 32'h0000_0002, 32'hDEAD_BEEF, 5'd9,  1'b1, 32'h0000_DEAD, 1'b1};
        vecs[7] = '{MEM_RH,  GPR_MEM, 32'h0000_0003, 32'h8011_2233, 5'd10, 1'b1, 32'h0000_0080, 1'b1};
        vecs[8] = '{MEM_WW,  GPR_IDLE, 32'h0000_0040, 32'h1234_5678, 5'd11, 1'b0, 32'h0, 1'b0};
        vecs[9] = '{MEM_IDLE, GPR_EXE, 32'hCAFE_F00D, 32'h0000_0000, 5'd12, 1'b1, 32'hCAFE_F00D, 1'b1};

        // Reset state
        rstn = 1'b0;
        halt = 1'b0;
        idle();
        cur_exp = '{wren: 1'b0, waddr: '0, wdata: '0, chk_dat: 1'b0};
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_wren", 64'(rf_wren), 64'd0);
        check("rst_commit", 64'(commit), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_instret", instret, 64'd0);
        step();
        step();
        rstn = 1'b1;
        @(negedge clk);
        check("rel_ready", 64'(ready), 64'd1);

        // Sustained throughput: ten back-to-back uops
        step();
        cc0 = commit_cnt;
        for (int i = 0; i < 10; i++) begin
            exe_uop(RF_ADDR_WIDTH'(i + 1), DATA_WIDTH'(32'h1000 + i));
            @(negedge clk);
            check("tp_ready", 64'(ready), 64'd1);
            if (i > 0) check("tp_commit", 64'(commit), 64'd1);
            step();
        end
        idle();
        @(negedge clk);
        check("tp_last_commit", 64'(commit), 64'd1);
        step();
        check("tp_commit_count", 64'(commit_cnt - cc0), 64'd10);
        check("tp_instret", instret, 64'd10);

        // Vector table: one uop at a time, retires the cycle after acceptance
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check("vec_ready", 64'(ready), 64'd1);
            step();
            idle();
            @(negedge clk);
            check("vec_commit", 64'(commit), 64'd1);
            step();
        end
        check("vec_instret", instret, 64'd20);

        // Halt back-pressure: only two of four valids are taken
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exe_uop(RF_ADDR_WIDTH'(20 + i), DATA_WIDTH'(32'hA0 + i));
            @(negedge clk);
            check("halt_ready", 64'(ready), (i < 2) ? 64'd1 : 64'd0);
            check("halt_commit", 64'(commit), 64'd0);
            step();
        end
        idle();
        @(negedge clk);
        check("halt_hold_ready", 64'(ready), 64'd0);
        check("halt_hold_instret", instret, 64'd20);
        step();
        halt = 1'b0;
        @(negedge clk);
        check("rel_commit0", 64'(commit), 64'd1);
        check("rel_ready0", 64'(ready), 64'd0);
        step();
        @(negedge clk);
        check("rel_commit1", 64'(commit), 64'd1);
        check("rel_ready1", 64'(ready), 64'd1);
        step();
        @(negedge clk);
        check("rel_commit2", 64'(commit), 64'd0);
        check("rel_instret", instret, 64'd22);
        step();
        exe_uop(5'd22, 32'hA2);
        step();
        exe_uop(5'd23, 32'hA3);
        step();
        idle();
        step();
        check("resend_instret", instret, 64'd24);

        // Reset mid-operation with the buffer full and the head retiring
        halt = 1'b1;
        exe_uop(5'd1, 32'h11);
        step();
        exe_uop(5'd2, 32'h22);
        step();
        idle();
        @(negedge clk);
        check("mid_full_ready", 64'(ready), 64'd0);
        step();
        halt = 1'b0;
        #2;
        check("mid_pre_commit", 64'(commit), 64'd1);
        check("mid_pre_wren", 64'(rf_wren), 64'd1);
        rstn = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_wren", 64'(rf_wren), 64'd0);
        check("mid_rst_commit", 64'(commit), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd0);
        check("mid_rst_instret", instret, 64'd0);
        check("mid_rst_waddr", 64'(rf_waddr), 64'd0);
        check("mid_rst_wdata", 64'(rf_wdata), 64'd0);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(ready), 64'd1);
        check("post_rst_commit", 64'(commit), 64'd0);
        step();
        exe_uop(5'd7, 32'h77);
        step();
        idle();
        @(negedge clk);
        check("post_rst_first_commit", 64'(commit), 64'd1);
        step();
        check("post_rst_instret", instret, 64'd1);

        step();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
# wb_unit

Write-back stage of the SCHOLAR RISC-V core, directly downstream of the memory unit. It accepts each completed micro-operation from MEM through a ready/valid handshake. For loads it aligns and sign/zero-extends the raw data-memory word, buffers up to two results, and drives the GPR file write port in order. It also counts retired micro-operations.

## Interface
Parameters:
- No module parameters. Widths come from core_pkg: DATA_WIDTH (32 or 64), ADDR_OFFSET_WIDTH, MEM_CTRL_WIDTH, GPR_CTRL_WIDTH, RF_ADDR_WIDTH (5).

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  system reset; one clock, reset asynchronous and active-low
- mem_valid_i  in  1  MEM result valid this cycle
- ready_o  out  1  WB can accept a result this cycle
- exe_out_i  in  DATA_WIDTH  EXE result; load byte address for loads
- mem_ctrl_i  in  MEM_CTRL_WIDTH  memory op of the uop (MEM_IDLE, loads, stores)
- d_m_rdata_i  in  DATA_WIDTH  raw memory word; valid with mem_valid_i on loads
- gpr_ctrl_i  in  GPR_CTRL_WIDTH  GPR_IDLE (no write) / GPR_EXE / GPR_MEM write source
- rd_i  in  RF_ADDR_WIDTH  destination register
- halt_i  in  1  freeze retirement (debug)
- rf_wren_o  out  1  GPR write enable
- rf_waddr_o  out  RF_ADDR_WIDTH  GPR write address
- rf_wdata_o  out  DATA_WIDTH  GPR write data
- commit_o  out  1  one-cycle pulse per retired uop
- instret_o  out  64  retired-uop count

## Operation
- **Accept.** A result is accepted when mem_valid_i && ready_o at a rising edge. Accepted fields are rd, write-enable source and write data. Write data is computed at capture time:
  - GPR_EXE → exe_out_i.
  - GPR_MEM → aligned load data.
- **Load alignment.**
  - off = exe_out_i[ADDR_OFFSET_WIDTH-1:0]; s = d_m_rdata_i >> (off*8).
  - MEM_RB/RBU: s[7:0], sign-/zero-extended.
  - MEM_RH/RHU: s[15:0], sign-/zero-extended.
  - MEM_RW: s[31:0], sign-extended on 64-bit; used unchanged on 32-bit.
  - MEM_RWU (64-bit only): s[31:0], zero-extended.
  - MEM_RD (64-bit only): s.
  - Bytes shifted in from beyond the word read as 0 (misaligned accesses are not trapped here).
- **Buffer.** Two-entry in-order FIFO: head plus skid; count 0..2.
  - ready_o = rstn_i && count != 2.
- **Retire.** The head retires in any cycle with count > 0 && !halt_i. In that cycle:
  - commit_o = 1.
  - rf_wren_o = 1 when head source ≠ GPR_IDLE and rd ≠ 0.
  - rf_waddr_o and rf_wdata_o come from the head. When rf_wren_o = 0 they hold the head values (0 when empty).
  - instret_o increments at the edge, wrapping at 2^64.
- **Simultaneous accept and retire.** Count unchanged. The new entry goes behind the remaining one, or becomes head when count was 1.
- **Stores, branches, GPR_IDLE uops.** Retire with commit_o = 1 and no write.

## Timing
- **Latency.** Accepted at edge N → retires (rf_wren_o/commit_o high) in cycle N..N+1, i.e. the cycle after the edge, if count was 0 and halt_i = 0.
- **Throughput.** One uop/cycle sustained when halt_i = 0.
- **halt_i.** Blocks retirement the same cycle. Two more results are accepted, then ready_o falls the cycle after the second acceptance.
- **Reset.** While rstn_i = 0:
  - count = 0; pending entries are dropped.
  - ready_o = 0, rf_wren_o = 0, commit_o = 0.
  - rf_waddr_o = 0, rf_wdata_o = 0, instret_o = 0.
  - All take effect immediately, without waiting for clk_i, even mid-operation.
  - ready_o is 1 in the first cycle after deassertion.
- **Contract violation.** mem_valid_i while ready_o = 0 is ignored.
- **Registering.** rf outputs are combinational from registered state only; no input→output combinational paths except ready_o from rstn_i.

## Structure
- **core_pkg additions:**
  - GPR_CTRL_WIDTH and GPR_IDLE/GPR_EXE/GPR_MEM.
  - Load encodings MEM_RB/RBU/RH/RHU/RW/RWU/RD, with bit 3 = 0 for reads, consistent with the existing MEM_* store codes.
  - RF_ADDR_WIDTH.
- **Sub-module:** load_aligner, combinational (rdata, offset, mem_ctrl → extended data). Reusable by a future LSU.
- **wb_unit contents:** FIFO, retirement control and the instret counter.

## Test plan
- **LB sign-extension (32-bit).** LB, exe_out = 0x103, rdata = 0x80112233, rd = 5, GPR_MEM → next cycle rf_wren_o = 1, waddr = 5, wdata = 0xFFFFFF80.
- **LHU zero-extension.** LHU, exe_out = 0x202, rdata = 0xBEEF1234 → wdata = 0x0000BEEF; 64-bit: LWU off 4 of 0x89ABCDEF_00000000 → 0x0000000089ABCDEF.
- **rd = 0.** GPR_EXE with rd = 0, exe_out = 0x55 → commit_o pulse, rf_wren_o = 0, instret +1.
- **Halt back-pressure.** halt_i = 1 with 4 back-to-back valids → two accepted, ready_o low afterward. Release halt → two retire in order on consecutive cycles, ready_o returns; instret +2 then +more as remaining uops are accepted.
- **Sustained throughput.** 10 consecutive valids, halt_i = 0 → ready_o stays 1, 10 commit pulses in 10 consecutive cycles, instret_o = 10.
- **Reset mid-operation.** Assert rstn_i low asynchronously between edges with count = 2 → rf_wren_o, commit_o, ready_o drop immediately, instret_o = 0. After release, first uop retires normally.
